// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - 4-way round-robin bus arbiter with one dead cycle between owners.
// Define BUS_ARB_TIMEOUT_EN to add forced release after MAX_HOLD grant cycles.
module bus_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

   state_t     state, state_nx;
   logic [1:0] ptr, ptr_nx;
   logic [1:0] owner, owner_nx;
   logic [1:0] win;
   logic       win_vld;
   logic       expire;
   logic [3:0] gnt_nx;
   logic [1:0] sel_nx;
   logic       bus_en_nx;

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
         $error("bus_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
      end
   endgenerate

   // Descending scan so the requester closest above ptr is written last and wins.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req[ptr + 2'(i)]) begin
            win     = ptr + 2'(i);
            win_vld = 1'b1;
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt;
   logic             timeout_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_cnt <= '0;
      else if (state == GRANT && state_nx == GRANT)
         hold_cnt <= hold_cnt + CNT_W'(1);
      else
         hold_cnt <= '0;
   end

   assign expire = (state == GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      timeout_nx = (state == GRANT) && req[owner] && expire;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timeout <= 1'b0;
      else
         timeout <= timeout_nx;
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= 2'd0;
         owner  <= 2'd0;
         gnt    <= 4'd0;
         sel    <= 2'd0;
         bus_en <= 1'b0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         owner  <= owner_nx;
         gnt    <= gnt_nx;
         sel    <= sel_nx;
         bus_en <= bus_en_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      owner_nx = owner;
      case (state)
         IDLE, TURN: begin
            if (win_vld) begin
               state_nx = GRANT;
               owner_nx = win;
               ptr_nx   = win + 2'd1;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            if (!req[owner] || expire)
               state_nx = TURN;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed from the next state so they register alongside it.
   always_comb begin
      gnt_nx    = 4'd0;
      sel_nx    = 2'd0;
      bus_en_nx = 1'b0;
      if (state_nx == GRANT) begin
         gnt_nx    = 4'b0001 << owner_nx;
         sel_nx    = owner_nx;
         bus_en_nx = 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb/tb_bus_arbiter4.sv - randomized and directed checks of bus_arbiter4 against a behavioural model.
module tb_bus_arbiter4;

   localparam int MAXH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'd0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       bus_en;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   bus_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .sel(sel), .bus_en(bus_en), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Model: owner index (-1 = bus free), rotating search start, cycles held so far.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_owner = -1;
            end else if (TO_ON && m_held >= MAXH) begin
               m_owner = -1;
               m_to    = 1'b1;
            end else begin
               m_held++;
            end
         end else begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (!found && req[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_ptr   = (c + 1) % 4;
                  m_held  = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (!rst) begin
         check("model_gnt", {28'd0, gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("model_sel", {30'd0, sel}, (m_owner >= 0) ? m_owner : 32'd0);
         check("model_bus_en", {31'd0, bus_en}, {31'd0, m_owner >= 0});
         check("model_timeout", {31'd0, timeout}, {31'd0, m_to});
      end
   end

   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      rst = 1'b1;
      req = r;
      @(negedge clk);
      @(negedge clk);
      check("rst_gnt", {28'd0, gnt}, 32'd0);
      check("rst_sel", {30'd0, sel}, 32'd0);
      check("rst_bus_en", {31'd0, bus_en}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      // Reset release with all requesting: requester 0 first, one edge later.
      do_reset(4'b1111);
      @(negedge clk);
      check("first_gnt", {28'd0, gnt}, 32'h1);
      check("first_sel", {30'd0, sel}, 32'd0);

      // Round robin: each owner holds two cycles, drops, re-raises in the dead cycle.
      for (int k = 0; k < 5; k++) begin
         check("rr_gnt_c1", {28'd0, gnt}, 32'd1 << (k % 4));
         @(negedge clk);
         check("rr_gnt_c2", {28'd0, gnt}, 32'd1 << (k % 4));
         req[k % 4] = 1'b0;
         @(negedge clk);
         check("rr_dead", {28'd0, gnt}, 32'd0);
         req[k % 4] = 1'b1;
         @(negedge clk);
      end

      // Wrap: owner 2 leaves ptr at 3, so 0 beats 2 for req 0101.
      do_reset(4'b0000);
      req = 4'b0100;
      @(negedge clk);
      check("wrap_g2", {28'd0, gnt}, 32'h4);
      req = 4'b0000;
      @(negedge clk);
      check("wrap_dead", {28'd0, gnt}, 32'h0);
      req = 4'b0101;
      @(negedge clk);
      check("wrap_g0", {28'd0, gnt}, 32'h1);
      req = 4'b0100;
      @(negedge clk);
      check("wrap_dead2", {28'd0, gnt}, 32'h0);
      @(negedge clk);
      check("wrap_g2b", {28'd0, gnt}, 32'h4);
      check("wrap_sel2", {30'd0, sel}, 32'd2);

      // Asynchronous reset between edges releases the bus immediately.
      #1 rst = 1'b1;
      #1 check("async_gnt", {28'd0, gnt}, 32'h0);
      check("async_bus_en", {31'd0, bus_en}, 32'd0);
      #1 rst = 1'b0;

      // Hold limit with two contenders.
      do_reset(4'b0011);
`ifdef BUS_ARB_TIMEOUT_EN
      for (int c = 0; c < MAXH; c++) begin
         @(negedge clk);
         check("to_hold", {28'd0, gnt}, 32'h1);
         check("to_low", {31'd0, timeout}, 32'd0);
      end
      @(negedge clk);
      check("to_dead", {28'd0, gnt}, 32'h0);
      check("to_pulse", {31'd0, timeout}, 32'd1);
      @(negedge clk);
      check("to_next", {28'd0, gnt}, 32'h2);
      check("to_clear", {31'd0, timeout}, 32'd0);
`else
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         check("hold_forever", {28'd0, gnt}, 32'h1);
         check("no_timeout", {31'd0, timeout}, 32'd0);
      end
`endif

      // Random traffic with mostly-held requests and occasional mid-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
         if ($urandom_range(0, 15) == 0)
            req = 4'($urandom);
         if ($urandom_range(0, 249) == 0) begin
            #1 rst = 1'b1;
            #1 check("rand_async_gnt", {28'd0, gnt}, 32'h0);
            #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
